data_memory_arbiter: RTL and testbench

- Shares the single data-memory port (12-bit word address, byte enables, one-cycle registered read latency, IO window at address bits 11/10) between two requesters.
- Port 0 is the core load/store unit; port 1 is the debug/loader/DMA port.
- Issues at most one transaction per cycle and routes the read data back to the issuing port one cycle later.
- Supports short locked sequences, e.g. multi-register IO updates, with a timeout.

---
 rtl/data_memory_arbiter_pkg.sv | 19 +
 rtl/data_memory_arbiter_pick.sv | 25 ++
 rtl/data_memory_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices, lock defaults.
package dmem_arb_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0        = 1'b0;
    localparam logic PORT1        = 1'b1;
    localparam int   LOCK_MAX_DEF = 16;
    localparam int   LOCK_CNT_W   = 8;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_pick.sv
// Two-input picker: a lone requester wins, contention goes to the port that is not last_gnt.
module dmem_arb_pick
    import dmem_arb_defs::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic pick_valid,
    output logic pick
);

    // Select a winner among the active requesters.
    always_comb begin
        pick_valid = req0 | req1;
        pick       = PORT0;
        if (req0 && req1) begin
            pick = other_port(last_gnt);
        end else if (req1) begin
            pick = PORT1;
        end else begin
            pick = PORT0;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port data-memory arbiter with locked sequences, lock timeout and read-data return routing.
// Build option DMEM_ARB_RR_EN: round-robin on contention in IDLE (default: port 0 has fixed priority).
module data_memory_arbiter
    import dmem_arb_defs::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [3:0]        be0,
    input  logic [3:0]        be1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteena,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              lock_timeout
);

    arb_state_e            state_r;
    logic [LOCK_CNT_W-1:0] lock_cnt_r;
    logic                  hand_r;
    logic                  hand_port_r;
    logic                  rd_pend_r;
    logic                  rd_port_r;
    logic                  lock_timeout_r;

    logic base_last_s;
    logic last_gnt_s;
    logic pick_valid_s;
    logic pick_s;
    logic sel0_s;
    logic sel1_s;
    logic gnt0_s;
    logic gnt1_s;
    logic any_gnt_s;
    logic gnt_port_s;
    logic gnt_we_s;
    logic own_port_s;
    logic own_lock_s;
    logic cnt_hit_s;
    logic rvalid0_s;
    logic rvalid1_s;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt_r;

    // Round-robin history: remember the most recent winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_r <= PORT1;
        end else if (any_gnt_s) begin
            last_gnt_r <= gnt_port_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign base_last_s = last_gnt_r;
`else
    assign base_last_s = PORT1;
`endif

    // After a forced release the timed-out port is treated as the last winner so the other side goes first.
    assign last_gnt_s = hand_r ? hand_port_r : base_last_s;

    dmem_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_gnt   (last_gnt_s),
        .pick_valid (pick_valid_s),
        .pick       (pick_s)
    );

    assign own_port_s = (state_r == OWN1) ? PORT1 : PORT0;
    assign own_lock_s = own_port_s ? lock1 : lock0;
    assign cnt_hit_s  = (lock_cnt_r == LOCK_CNT_W'(LOCK_MAX - 1));

    // Eligibility: the picker decides in IDLE, otherwise only the owner may be selected.
    always_comb begin
        sel0_s = 1'b0;
        sel1_s = 1'b0;
        case (state_r)
            IDLE: begin
                sel0_s = pick_valid_s & (pick_s == PORT0);
                sel1_s = pick_valid_s & (pick_s == PORT1);
            end
            OWN0: sel0_s = 1'b1;
            OWN1: sel1_s = 1'b1;
            default: begin
                sel0_s = 1'b0;
                sel1_s = 1'b0;
            end
        endcase
    end

    assign gnt0_s     = req0 & sel0_s & ~reset;
    assign gnt1_s     = req1 & sel1_s & ~reset;
    assign any_gnt_s  = gnt0_s | gnt1_s;
    assign gnt_port_s = gnt1_s;
    assign gnt_we_s   = gnt1_s ? we1 : (gnt0_s & we0);

    assign gnt0        = gnt0_s;
    assign gnt1        = gnt1_s;
    assign mem_address = gnt1_s ? addr1  : addr0;
    assign mem_byteena = gnt1_s ? be1    : be0;
    assign mem_data    = gnt1_s ? wdata1 : wdata0;
    assign mem_wren    = gnt_we_s;

    // Ownership FSM with lock counter, forced release and hand-over flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            lock_cnt_r     <= {LOCK_CNT_W{1'b0}};
            hand_r         <= 1'b0;
            hand_port_r    <= PORT0;
            lock_timeout_r <= 1'b0;
        end else begin
            lock_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    lock_cnt_r <= {LOCK_CNT_W{1'b0}};
                    if (any_gnt_s) begin
                        hand_r <= 1'b0;
                    end
                    if (gnt0_s && lock0) begin
                        state_r <= OWN0;
                    end else if (gnt1_s && lock1) begin
                        state_r <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_lock_s) begin
                        state_r    <= IDLE;
                        lock_cnt_r <= {LOCK_CNT_W{1'b0}};
                    end else if (cnt_hit_s) begin
                        state_r        <= IDLE;
                        lock_cnt_r     <= LOCK_CNT_W'(LOCK_MAX);
                        lock_timeout_r <= 1'b1;
                        hand_r         <= 1'b1;
                        hand_port_r    <= own_port_s;
                    end else if (lock_cnt_r != {LOCK_CNT_W{1'b1}}) begin
                        lock_cnt_r <= lock_cnt_r + LOCK_CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Read-return tracking: memory answers one cycle after the grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend_r <= 1'b0;
            rd_port_r <= PORT0;
        end else begin
            rd_pend_r <= any_gnt_s & ~gnt_we_s;
            rd_port_r <= gnt_port_s;
        end
    end

    // A read in flight when reset arrives is dropped rather than delivered.
    assign rvalid0_s = rd_pend_r & (rd_port_r == PORT0) & ~reset;
    assign rvalid1_s = rd_pend_r & (rd_port_r == PORT1) & ~reset;

    assign rvalid0      = rvalid0_s;
    assign rvalid1      = rvalid1_s;
    assign rdata0       = rvalid0_s ? mem_q : {DATA_W{1'b0}};
    assign rdata1       = rvalid1_s ? mem_q : {DATA_W{1'b0}};
    assign lock_timeout = lock_timeout_r;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter against a transaction-level reference model.
module tb_data_memory_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [3:0]        be0, be1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_wren, lock_timeout;
    logic [DATA_W-1:0] rdata0, rdata1, mem_data, mem_q;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;

    logic [DATA_W-1:0] mem     [0:4095];
    logic [DATA_W-1:0] ref_mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owner (-1 none), cycles held, favoured port after timeout, last winner, pending read.
    int                m_owner, m_hold, m_hand, m_last, m_pend, m_to, m_w;
    logic [DATA_W-1:0] m_pend_data;
    logic              e_gnt0, e_gnt1, e_wren, e_rv0, e_rv1, e_to;
    logic [ADDR_W-1:0] e_addr;
    logic [3:0]        e_be;
    logic [DATA_W-1:0] e_data, e_rd0, e_rd1;

    data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
        .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .lock_timeout(lock_timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Memory with one-cycle registered read and byte-enabled write.
    always @(posedge clock) begin
        mem_q <= mem[mem_address];
        if (mem_wren) mem[mem_address] = merge(mem[mem_address], mem_data, mem_byteena);
    end

    function automatic logic p_req(input int p);   return (p == 1) ? req1 : req0;     endfunction
    function automatic logic p_we(input int p);    return (p == 1) ? we1 : we0;       endfunction
    function automatic logic p_lock(input int p);  return (p == 1) ? lock1 : lock0;   endfunction
    function automatic logic [ADDR_W-1:0] p_addr(input int p); return (p == 1) ? addr1 : addr0; endfunction
    function automatic logic [3:0] p_be(input int p);          return (p == 1) ? be1 : be0;     endfunction
    function automatic logic [DATA_W-1:0] p_wdata(input int p); return (p == 1) ? wdata1 : wdata0; endfunction

    task automatic model_eval();
        if (reset) m_w = -1;
        else if (m_owner >= 0) m_w = p_req(m_owner) ? m_owner : -1;
        else if (req0 && req1) begin
            if (m_hand >= 0) m_w = m_hand;
`ifdef DMEM_ARB_RR_EN
            else m_w = 1 - m_last;
`else
            else m_w = 0;
`endif
        end
        else if (req0) m_w = 0;
        else if (req1) m_w = 1;
        else m_w = -1;
        e_gnt0 = (m_w == 0);
        e_gnt1 = (m_w == 1);
        e_wren = (m_w >= 0) && p_we(m_w);
        e_addr = (m_w == 1) ? addr1 : addr0;
        e_be   = (m_w == 1) ? be1 : be0;
        e_data = (m_w == 1) ? wdata1 : wdata0;
        e_rv0  = !reset && (m_pend == 0);
        e_rv1  = !reset && (m_pend == 1);
        e_rd0  = e_rv0 ? m_pend_data : 32'h0;
        e_rd1  = e_rv1 ? m_pend_data : 32'h0;
        e_to   = (m_to != 0);
    endtask

    task automatic model_commit();
        if (reset) begin
            m_owner = -1; m_hold = 0; m_hand = -1; m_last = 1; m_pend = -1; m_to = 0;
        end else begin
            m_to = 0;
            m_pend = -1;
            if (m_w >= 0) begin
                m_last = m_w;
                if (p_we(m_w)) ref_mem[p_addr(m_w)] = merge(ref_mem[p_addr(m_w)], p_wdata(m_w), p_be(m_w));
                else begin m_pend = m_w; m_pend_data = ref_mem[p_addr(m_w)]; end
            end
            if (m_owner < 0) begin
                if (m_w >= 0) begin
                    m_hand = -1;
                    if (p_lock(m_w)) begin m_owner = m_w; m_hold = 0; end
                end
            end else if (!p_lock(m_owner)) m_owner = -1;
            else if (m_hold == LOCK_MAX - 1) begin m_hand = 1 - m_owner; m_owner = -1; m_to = 1; end
            else m_hold++;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        be0 = 4'hF; be1 = 4'hF; addr0 = 12'h000; addr1 = 12'h000; wdata0 = 32'h0; wdata1 = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; addr0 = 12'h0F0; addr1 = 12'h0F1;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got=%0b exp=0", gnt0); end
            n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1 got=%0b exp=0", gnt1); end
            n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%0b exp=0", mem_wren); end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        settle();
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%0b%0b exp=00", rvalid0, rvalid1); end
        n_checks++; if (lock_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%0b exp=0", lock_timeout); end
        tick();
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h004; be0 = 4'hF;
        settle();
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL read_gnt0 got=%0b exp=1", gnt0); end
        n_checks++; if (mem_address !== 12'h004) begin n_fail++; $display("FAIL read_addr got=%h exp=004", mem_address); end
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL read_rv1_c0 got=%0b exp=0", rvalid1); end
        tick();
        req0 = 1'b0;
        settle();
        n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL read_rv0 got=%0b exp=1", rvalid0); end
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata0 got=%h exp=deadbeef", rdata0); end
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL read_rv1_c1 got=%0b exp=0", rvalid1); end
        tick();
    endtask

    task automatic test_contention();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 12'h100; addr1 = 12'h200;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin req0 = 1'b0; req1 = 1'b0; end
            settle();
            n_checks++; if (gnt0 !== e_gnt0 || gnt1 !== e_gnt1) begin n_fail++; $display("FAIL cont_gnt c=%0d got=%0b%0b exp=%0b%0b", c, gnt0, gnt1, e_gnt0, e_gnt1); end
            n_checks++; if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1) begin n_fail++; $display("FAIL cont_rv c=%0d got=%0b%0b exp=%0b%0b", c, rvalid0, rvalid1, e_rv0, e_rv1); end
            n_checks++; if (rdata0 !== e_rd0 || rdata1 !== e_rd1) begin n_fail++; $display("FAIL cont_rdata c=%0d got=%h/%h exp=%h/%h", c, rdata0, rdata1, e_rd0, e_rd1); end
            tick();
            if (m_w == 0) addr0 = addr0 + 12'h001;
            if (m_w == 1) addr1 = addr1 + 12'h001;
        end
    endtask

    task automatic test_locked_writes();
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 12'h800; wdata1 = 32'hA5A5_0001; be1 = 4'hF;
        settle();
        n_checks++; if (gnt1 !== 1'b1 || mem_wren !== 1'b1) begin n_fail++; $display("FAIL lockwr_a got gnt1=%0b wren=%0b exp=1/1", gnt1, mem_wren); end
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005; addr1 = 12'h801; wdata1 = 32'hA5A5_0002;
        settle();
        n_checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_wren !== 1'b1) begin n_fail++; $display("FAIL lockwr_b got gnt0=%0b gnt1=%0b wren=%0b exp=0/1/1", gnt0, gnt1, mem_wren); end
        n_checks++; if (mem_address !== 12'h801) begin n_fail++; $display("FAIL lockwr_b_addr got=%h exp=801", mem_address); end
        tick();
        req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
        settle();
        n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL lockwr_c_gnt0 got=%0b exp=0", gnt0); end
        tick();
        settle();
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL lockwr_d_gnt0 got=%0b exp=1", gnt0); end
        tick();
        req0 = 1'b0;
        settle();
        n_checks++; if (mem[12'h800] !== 32'hA5A5_0001 || mem[12'h801] !== 32'hA5A5_0002) begin n_fail++; $display("FAIL lockwr_mem got=%h/%h exp=a5a50001/a5a50002", mem[12'h800], mem[12'h801]); end
        tick();
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 12'h300;
        req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 12'h310;
        for (int c = 0; c < 20; c++) begin
            settle();
            n_checks++; if (gnt0 !== e_gnt0 || gnt1 !== e_gnt1) begin n_fail++; $display("FAIL tmo_gnt c=%0d got=%0b%0b exp=%0b%0b", c, gnt0, gnt1, e_gnt0, e_gnt1); end
            n_checks++; if (lock_timeout !== e_to) begin n_fail++; $display("FAIL tmo_pulse c=%0d got=%0b exp=%0b", c, lock_timeout, e_to); end
            if (lock_timeout === 1'b1) begin
                pulses++;
                n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL tmo_handover c=%0d got gnt1=%0b exp=1", c, gnt1); end
            end
            tick();
            if (m_w == 1) req1 = 1'b0;
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL tmo_count got=%0d exp=1", pulses); end
        idle_inputs();
        settle();
        tick();
    endtask

    task automatic test_reset_mid_lock();
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 12'h820; wdata1 = 32'h0000_0055;
        settle();
        n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL rml_lock_gnt1 got=%0b exp=1", gnt1); end
        tick();
        we1 = 1'b0;
        settle();
        n_checks++; if (gnt1 !== 1'b1 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL rml_read_gnt1 got gnt1=%0b wren=%0b exp=1/0", gnt1, mem_wren); end
        tick();
        reset = 1'b1; req0 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        settle();
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL rml_rv1 got=%0b exp=0", rvalid1); end
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL rml_in_reset got=%0b%0b wren=%0b exp=00/0", gnt0, gnt1, mem_wren); end
        tick();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; addr0 = 12'h004;
        settle();
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL rml_idle got=%0b%0b exp=10", gnt0, gnt1); end
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL rml_rv1_after got=%0b exp=0", rvalid1); end
        tick();
        idle_inputs();
        settle();
        n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rml_rv0 got=%0b/%h exp=1/deadbeef", rvalid0, rdata0); end
        tick();
    endtask

    task automatic test_byte_write();
        req0 = 1'b1; we0 = 1'b1; be0 = 4'b0011; addr0 = 12'h010; wdata0 = 32'h1234_5678;
        settle();
        n_checks++; if (mem_byteena !== 4'b0011) begin n_fail++; $display("FAIL bw_be got=%b exp=0011", mem_byteena); end
        n_checks++; if (mem_wren !== 1'b1 || gnt0 !== 1'b1) begin n_fail++; $display("FAIL bw_wren got wren=%0b gnt0=%0b exp=1/1", mem_wren, gnt0); end
        tick();
        req0 = 1'b0; we0 = 1'b0; be0 = 4'hF;
        settle();
        n_checks++; if (mem_wren !== 1'b0 || rvalid0 !== 1'b0) begin n_fail++; $display("FAIL bw_after got wren=%0b rv0=%0b exp=0/0", mem_wren, rvalid0); end
        tick();
        req0 = 1'b1;
        settle();
        tick();
        req0 = 1'b0;
        settle();
        n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hAAAA_5678) begin n_fail++; $display("FAIL bw_readback got=%0b/%h exp=1/aaaa5678", rvalid0, rdata0); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!req0) begin
                req0 = $urandom_range(0, 1); we0 = $urandom_range(0, 1); addr0 = 12'($urandom);
                be0 = 4'($urandom); wdata0 = $urandom; lock0 = ($urandom_range(0, 2) == 0);
            end
            if (!req1) begin
                req1 = $urandom_range(0, 1); we1 = $urandom_range(0, 1); addr1 = 12'($urandom);
                be1 = 4'($urandom); wdata1 = $urandom; lock1 = ($urandom_range(0, 2) == 0);
            end
            settle();
            n_checks++; if (gnt0 !== e_gnt0 || gnt1 !== e_gnt1) begin n_fail++; $display("FAIL rnd_gnt c=%0d got=%0b%0b exp=%0b%0b", c, gnt0, gnt1, e_gnt0, e_gnt1); end
            n_checks++; if (mem_wren !== e_wren) begin n_fail++; $display("FAIL rnd_wren c=%0d got=%0b exp=%0b", c, mem_wren, e_wren); end
            n_checks++; if (mem_address !== e_addr || mem_byteena !== e_be || mem_data !== e_data) begin n_fail++; $display("FAIL rnd_mem c=%0d got=%h/%b/%h exp=%h/%b/%h", c, mem_address, mem_byteena, mem_data, e_addr, e_be, e_data); end
            n_checks++; if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1) begin n_fail++; $display("FAIL rnd_rv c=%0d got=%0b%0b exp=%0b%0b", c, rvalid0, rvalid1, e_rv0, e_rv1); end
            n_checks++; if (rdata0 !== e_rd0 || rdata1 !== e_rd1) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, rdata0, rdata1, e_rd0, e_rd1); end
            n_checks++; if (lock_timeout !== e_to) begin n_fail++; $display("FAIL rnd_timeout c=%0d got=%0b exp=%0b", c, lock_timeout, e_to); end
            tick();
            if (m_w == 0) req0 = 1'b0;
            if (m_w == 1) req1 = 1'b0;
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        mem[12'h004] = 32'hDEADBEEF; ref_mem[12'h004] = 32'hDEADBEEF;
        mem[12'h010] = 32'hAAAA_AAAA; ref_mem[12'h010] = 32'hAAAA_AAAA;
        m_owner = -1; m_hold = 0; m_hand = -1; m_last = 1; m_pend = -1; m_to = 0; m_w = -1;
        m_pend_data = 32'h0;
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_single_read();
        test_contention();
        test_locked_writes();
        test_timeout();
        test_reset_mid_lock();
        test_byte_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
